// File: rtl/vedic_mult_seq.sv
// vedic_mult_seq
// Sequential Urdhva-Tiryagbhyam multiplier. A single H x H (H = WIDTH/2)
// vertical-and-crosswise core is reused over four cycles to build the
// 2*WIDTH-bit product of two WIDTH-bit operands. Unsigned or two's-complement
// operation is chosen per transaction with sgn.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   ai, bi     WIDTH-bit operands, captured on accept
//   sgn        1 = signed operands/result, captured on accept
//   in_valid   operand request
//   in_ready   high in IDLE only
//   sout       registered 2*WIDTH-bit product, stable while out_valid
//   out_valid  sout holds a result
//   out_ready  consumer takes the result
//   busy       high in any state other than IDLE
module vedic_mult_seq #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   ai,
    input  logic [WIDTH-1:0]   bi,
    input  logic               sgn,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] sout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    localparam int H  = WIDTH / 2;
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(H + 1);   // width of one column's bit count

    typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             neg;
    logic [W2-1:0]    acc;

    logic [H-1:0]     core_x;
    logic [H-1:0]     core_y;
    logic [WIDTH-1:0] core_p;
    logic [W2-1:0]    term;
    logic [W2-1:0]    acc_sum;
    logic [CW-1:0]    col_sum [2*H-1];

    // Magnitude of a possibly signed operand. -(-2^(W-1)) wraps back to
    // 2^(W-1), which is exactly the right unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic s);
        return (s && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    // Crosswise sum for column k: number of set bit-products x[i]&y[k-i].
    function automatic logic [CW-1:0] column_count(input logic [H-1:0] x,
                                                   input logic [H-1:0] y,
                                                   input int k);
        logic [CW-1:0] s;
        s = '0;
        for (int i = 0; i < H; i++) begin
            if ((k - i) >= 0 && (k - i) < H) begin
                s = s + CW'(x[i] & y[k - i]);
            end
        end
        return s;
    endfunction

    // Operand halves and weight of the partial product for each step.
    always_comb begin
        core_x = a_mag[H-1:0];
        core_y = b_mag[H-1:0];
        case (state)
            PP1: begin
                core_x = a_mag[WIDTH-1:H];
                core_y = b_mag[H-1:0];
            end
            PP2: begin
                core_x = a_mag[H-1:0];
                core_y = b_mag[WIDTH-1:H];
            end
            PP3: begin
                core_x = a_mag[WIDTH-1:H];
                core_y = b_mag[WIDTH-1:H];
            end
            default: ;
        endcase
    end

    // Vertical-and-crosswise core: one column count per output weight.
    generate
        for (genvar gi = 0; gi < 2 * H - 1; gi++) begin : g_col
            assign col_sum[gi] = column_count(core_x, core_y, gi);
        end
    endgenerate

    // Column counts overlap into higher weights; summing them resolves the
    // carries. The true product fits in WIDTH bits, so truncation is exact.
    always_comb begin
        core_p = '0;
        for (int k = 0; k < 2 * H - 1; k++) begin
            core_p = core_p + (WIDTH'(col_sum[k]) << k);
        end
    end

    always_comb begin
        term = W2'(core_p);
        case (state)
            PP1, PP2: term = W2'(core_p) << H;
            PP3:      term = W2'(core_p) << WIDTH;
            default:  ;
        endcase
        acc_sum = acc + term;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_mag     <= '0;
            b_mag     <= '0;
            neg       <= 1'b0;
            acc       <= '0;
            sout      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_mag <= magnitude(ai, sgn);
                        b_mag <= magnitude(bi, sgn);
                        neg   <= sgn & (ai[WIDTH-1] ^ bi[WIDTH-1]);
                        acc   <= '0;
                        state <= PP0;
                    end
                end
                PP0: begin
                    acc   <= acc_sum;
                    state <= PP1;
                end
                PP1: begin
                    acc   <= acc_sum;
                    state <= PP2;
                end
                PP2: begin
                    acc   <= acc_sum;
                    state <= PP3;
                end
                PP3: begin
                    sout      <= neg ? (~acc_sum + W2'(1)) : acc_sum;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded from state only: no path from in_valid or out_ready.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Testbench for vedic_mult_seq: WIDTH=64 and WIDTH=16 instances, directed
// vectors with hand-computed products, scoreboard queues drained by monitors.
module tb_vedic_mult_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // ---------------- WIDTH = 64 instance ----------------
    logic [63:0]  ai64, bi64;
    logic         sgn64, in_valid64, in_ready64, out_valid64, out_ready64, busy64;
    logic [127:0] sout64;

    vedic_mult_seq #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .ai(ai64), .bi(bi64), .sgn(sgn64),
        .in_valid(in_valid64), .in_ready(in_ready64), .sout(sout64),
        .out_valid(out_valid64), .out_ready(out_ready64), .busy(busy64)
    );

    // ---------------- WIDTH = 16 instance ----------------
    logic [15:0]  ai16, bi16;
    logic         sgn16, in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [31:0]  sout16;

    vedic_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .ai(ai16), .bi(bi16), .sgn(sgn16),
        .in_valid(in_valid16), .in_ready(in_ready16), .sout(sout16),
        .out_valid(out_valid16), .out_ready(out_ready16), .busy(busy16)
    );

    logic [127:0] exp_q64 [$];
    logic [31:0]  exp_q16 [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: a result is consumed at the next rising edge whenever
    // out_valid & out_ready are seen at the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid64 && out_ready64) begin
            if (exp_q64.size() == 0) begin
                chk("unexpected_result64", sout64, 128'd0);
            end else begin
                logic [127:0] e;
                e = exp_q64.pop_front();
                chk("result64", sout64, e);
                $display("w64 result sout=%h expected=%h", sout64, e);
            end
        end
        if (!rst && out_valid16 && out_ready16) begin
            if (exp_q16.size() == 0) begin
                chk("unexpected_result16", 128'(sout16), 128'd0);
            end else begin
                logic [31:0] e;
                e = exp_q16.pop_front();
                chk("result16", 128'(sout16), 128'(e));
                $display("w16 result sout=%h expected=%h", sout16, e);
            end
        end
    end

    int last_acc64;
    int last_acc16;

    // Wait for in_ready, present operands for one edge. Returns after #1.
    task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic s,
                           input logic [127:0] e, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready64 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("timeout_in_ready64", 128'd0, 128'd1);
        end
        ai64 = a; bi64 = b; sgn64 = s; in_valid64 = 1'b1;
        if (push) exp_q64.push_back(e);
        @(posedge clk);
        #1;
        last_acc64 = cyc;
        in_valid64 = 1'b0;
        ai64 = ~a;   // changes after accept must not matter
        sgn64 = ~s;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input logic [31:0] e);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready16 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("timeout_in_ready16", 128'd0, 128'd1);
        end
        ai16 = a; bi16 = b; sgn16 = s; in_valid16 = 1'b1;
        exp_q16.push_back(e);
        @(posedge clk);
        #1;
        last_acc16 = cyc;
        in_valid16 = 1'b0;
        bi16 = ~b;
    endtask

    // Count rising edges from accept until out_valid (bounded).
    task automatic latency64(input string name);
        int n;
        n = 0;
        while (!out_valid64 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 128'(n), 128'd4);
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] e64;
        ai64 = '0; bi64 = '0; sgn64 = 0; in_valid64 = 0; out_ready64 = 1;
        ai16 = '0; bi16 = '0; sgn16 = 0; in_valid16 = 0; out_ready16 = 1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 128'(out_valid64), 128'd0);
        chk("reset_sout", sout64, 128'd0);
        chk("reset_busy", 128'(busy64), 128'd0);
        chk("reset_in_ready", 128'(in_ready64), 128'd1);
        rst = 1'b0;

        // Unsigned all-ones, with latency check.
        issue64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b1);
        chk("busy_after_accept", 128'(busy64), 128'd1);
        latency64("latency_allones");

        // Signed vectors and the per-transaction mode switch.
        issue64(-64'sd3, 64'd5, 1'b1, -128'sd15, 1'b1);
        issue64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
                128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b1);
        chk("initiation_interval", 128'(cyc - last_acc64), 128'd0);
        issue64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd1, 1'b1);
        issue64(-64'sd3, 64'd5, 1'b0, 128'h4_FFFF_FFFF_FFFF_FFF1, 1'b1);
        drain(8);

        // Backpressure: hold DONE for 10 cycles while disturbing inputs.
        out_ready64 = 1'b0;
        e64 = 128'd6 * 128'd7;
        issue64(64'd6, 64'd7, 1'b0, e64, 1'b1);
        latency64("latency_bp");
        for (int i = 0; i < 10; i++) begin
            in_valid64 = i[0];
            ai64 = 64'(i * 1234567);
            @(posedge clk);
            #1;
            chk("bp_sout", sout64, e64);
            chk("bp_out_valid", 128'(out_valid64), 128'd1);
            chk("bp_in_ready", 128'(in_ready64), 128'd0);
        end
        in_valid64 = 1'b0;
        out_ready64 = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_consumed", 128'(out_valid64), 128'd0);
        chk("bp_idle_after_consume", 128'(in_ready64), 128'd1);
        chk("bp_sout_kept", sout64, e64);

        // Reset during PP2: discarded, nothing produced.
        issue64(64'hDEAD_BEEF, 64'h1234_5678, 1'b0, 128'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(out_valid64), 128'd0);
        chk("midrst_sout", sout64, 128'd0);
        chk("midrst_busy", 128'(busy64), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue64(64'd7, 64'd9, 1'b0, 128'd63, 1'b1);
        latency64("latency_after_reset");
        drain(3);

        // WIDTH = 16 directed vectors.
        issue16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        issue16(16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000);
        issue16(16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        issue16(16'hFFFF, 16'h0002, 1'b1, 32'hFFFF_FFFE);
        // Back-to-back random pairs against an arithmetic reference.
        for (int i = 0; i < 100; i++) begin
            logic [15:0] a, b;
            logic s;
            logic [31:0] r;
            int prev;
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom_range(0, 1));
            if (s) r = 32'($signed(a)) * 32'($signed(b));
            else   r = {16'd0, a} * {16'd0, b};
            prev = last_acc16;
            issue16(a, b, s, r);
            if (i > 0) chk("interval16", 128'(last_acc16 - prev), 128'd6);
        end
        drain(10);

        chk("queue64_empty", 128'(exp_q64.size()), 128'd0);
        chk("queue16_empty", 128'(exp_q16.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
